// File: rtl/exec_wb_ctrl.sv
// Execute/writeback sequencer around an external combinational ALU with a 16x16 regfile and 5-bit PSR.
// Optional build macro REG_ZERO_EN: r0 is hard-wired to zero (reads 0, writes discarded).
module exec_wb_ctrl #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       instr_op,
  input  logic [3:0]       instr_rdest,
  input  logic [3:0]       instr_rsrc,
  input  logic             instr_imm_sel,
  input  logic [IMM_W-1:0] instr_imm,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [7:0]       alu_op,
  input  logic [15:0]      alu_out,
  input  logic [4:0]       alu_flags,
  output logic             done,
  output logic [15:0]      result,
  output logic [4:0]       psr,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [15:0]      dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  logic [1:0]       r_state;
  logic [7:0]       r_op;
  logic [3:0]       r_rdest;
  logic [3:0]       r_rsrc;
  logic             r_imm_sel;
  logic [IMM_W-1:0] r_imm;
  logic [15:0]      r_opa;
  logic [15:0]      r_opb;
  logic [7:0]       r_alu_op;
  logic [15:0]      r_cap_out;
  logic [4:0]       r_cap_flags;
  logic [15:0]      r_result;
  logic [4:0]       r_psr;
  logic [15:0]      r_regs [NREGS];

  logic [15:0] w_rf_a;
  logic [15:0] w_rf_b;
  logic [15:0] w_sext;
  logic        w_is_alu_wr;
  logic        w_is_mov;
  logic        w_is_cmp;
  logic        w_legal;
  logic        w_rf_we;
  logic [15:0] w_wdata;

  assign w_sext = {{(16-IMM_W){r_imm[IMM_W-1]}}, r_imm};

  always_comb begin
    w_rf_a = r_regs[r_rdest];
    w_rf_b = r_regs[r_rsrc];
`ifdef REG_ZERO_EN
    if (r_rdest == 4'd0) w_rf_a = '0;
    if (r_rsrc == 4'd0)  w_rf_b = '0;
`endif
  end

  always_comb begin
    w_is_alu_wr = 1'b0;
    w_is_mov    = 1'b0;
    w_is_cmp    = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_LSH, OP_ASHU: w_is_alu_wr = 1'b1;
      OP_MOV: w_is_mov = 1'b1;
      OP_CMP: w_is_cmp = 1'b1;
      default: ;
    endcase
    w_legal = w_is_alu_wr | w_is_mov | w_is_cmp;
  end

  // MOV bypasses the ALU and writes the selected B operand directly
  always_comb begin
    w_wdata = w_is_mov ? r_opb : r_cap_out;
    w_rf_we = (r_state == S_WB) && (w_is_alu_wr || w_is_mov);
`ifdef REG_ZERO_EN
    if (r_rdest == 4'd0) w_rf_we = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_rdest     <= '0;
      r_rsrc      <= '0;
      r_imm_sel   <= 1'b0;
      r_imm       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_alu_op    <= '0;
      r_cap_out   <= '0;
      r_cap_flags <= '0;
      r_result    <= '0;
      r_psr       <= '0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op      <= instr_op;
            r_rdest   <= instr_rdest;
            r_rsrc    <= instr_rsrc;
            r_imm_sel <= instr_imm_sel;
            r_imm     <= instr_imm;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_opa    <= w_rf_a;
          r_opb    <= r_imm_sel ? w_sext : w_rf_b;
          r_alu_op <= r_op;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_cap_out   <= alu_out;
          r_cap_flags <= alu_flags;
          if (w_is_mov)
            r_result <= r_opb;
          else if (w_legal)
            r_result <= alu_out;
          else
            r_result <= '0;
          r_state <= S_WB;
        end
        default: begin
          if (w_rf_we) r_regs[r_rdest] <= w_wdata;
          if (w_is_alu_wr || w_is_cmp) r_psr <= r_cap_flags;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign done        = (r_state == S_WB);
  assign illegal     = (r_state == S_WB) && !w_legal;
  assign alu_a       = r_opa;
  assign alu_b       = r_opb;
  assign alu_op      = r_alu_op;
  assign result      = r_result;
  assign psr         = r_psr;

  always_comb begin
    dbg_data = r_regs[dbg_addr];
`ifdef REG_ZERO_EN
    if (dbg_addr == 4'd0) dbg_data = '0;
`endif
  end

endmodule
